// File: rtl/aes_key_sched.sv
`default_nettype none
// ============================================================================
//  Module   : aes_key_sched (with round function aes_keyexp)
//  Brief    : AES-128 key schedule; loads a 4-beat key, expands 10 round keys
//  Revision : 1.0  initial release
// ============================================================================

module aes_keyexp (
  input  logic [3:0]   rnd,
  input  logic [127:0] di_key,
  output logic [127:0] do_key
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 (2+4+...+128), then the FIPS affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [7:0]  w_rcon;
  logic [31:0] w_temp;
  logic [31:0] w_o0, w_o1, w_o2, w_o3;

  always_comb begin
    w_rcon = 8'h00;
    case (rnd)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // SubWord(RotWord(w3)) xor Rcon
  assign w_temp = {sbox(di_key[23:16]) ^ w_rcon, sbox(di_key[15:8]),
                   sbox(di_key[7:0]), sbox(di_key[31:24])};

  assign w_o0   = di_key[127:96] ^ w_temp;
  assign w_o1   = di_key[95:64]  ^ w_o0;
  assign w_o2   = di_key[63:32]  ^ w_o1;
  assign w_o3   = di_key[31:0]   ^ w_o2;
  assign do_key = {w_o0, w_o1, w_o2, w_o3};

endmodule

module aes_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_vld,
  output logic         key_rdy,
  input  logic [31:0]  key_in,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         done,
  output logic         busy
);

  localparam logic [3:0] C_LAST_RND = 4'd10;

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, READY} state_t;

  state_t       r_state;
  logic [1:0]   r_beat;
  logic [3:0]   r_round;
  logic         r_done;
  logic         r_busy;
  logic         r_key_rdy;
  logic [127:0] r_rk_out;
  logic [127:0] r_rk [0:10];

  logic         w_xfer;
  logic [3:0]   w_rnd;
  logic [127:0] w_di_key;
  logic [127:0] w_do_key;

  assign w_xfer   = key_vld & r_key_rdy;
  // Outside EXPAND the round function sees a harmless round 1 on rk[0].
  assign w_rnd    = (r_state == EXPAND) ? r_round : 4'd1;
  assign w_di_key = r_rk[w_rnd - 4'd1];

  aes_keyexp u_keyexp (
    .rnd    (w_rnd),
    .di_key (w_di_key),
    .do_key (w_do_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_beat    <= 2'd0;
      r_round   <= 4'd0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_key_rdy <= 1'b1;
      for (int i = 0; i < 11; i++) r_rk[i] <= '0;
    end else begin
      if (w_xfer) begin
        case (r_beat)
          2'd0:    r_rk[0][127:96] <= key_in;
          2'd1:    r_rk[0][95:64]  <= key_in;
          2'd2:    r_rk[0][63:32]  <= key_in;
          default: r_rk[0][31:0]   <= key_in;
        endcase
      end
      case (r_state)
        IDLE, READY: begin
          if (w_xfer) begin
            r_state <= LOAD;
            r_beat  <= 2'd1;
            r_done  <= 1'b0;
          end
        end
        LOAD: begin
          if (w_xfer) begin
            if (r_beat == 2'd3) begin
              r_state   <= EXPAND;
              r_round   <= 4'd1;
              r_beat    <= 2'd0;
              r_busy    <= 1'b1;
              r_key_rdy <= 1'b0;
            end else begin
              r_beat <= r_beat + 2'd1;
            end
          end
        end
        EXPAND: begin
          r_rk[r_round] <= w_do_key;
          if (r_round == C_LAST_RND) begin
            r_state   <= READY;
            r_round   <= 4'd0;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_key_rdy <= 1'b1;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rk_out <= '0;
    else if (rk_idx <= C_LAST_RND)
      r_rk_out <= r_rk[rk_idx];
    else
      r_rk_out <= '0;
  end

  assign key_rdy = r_key_rdy;
  assign rk_out  = r_rk_out;
  assign done    = r_done;
  assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_key_sched
//  Brief    : Self-checking bench for aes_key_sched against a FIPS-197 model
//  Revision : 1.0  initial release
// ============================================================================

module tb_aes_key_sched;

  logic         clk;
  logic         rst_n;
  logic         key_vld;
  logic         key_rdy;
  logic [31:0]  key_in;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         done;
  logic         busy;

  int errors;
  int checks;

  localparam logic [127:0] C_FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] C_FIPS_RK1 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] C_FIPS_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] C_ZERO_RK10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  logic [127:0] m_rk [0:10];

  aes_key_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_vld (key_vld),
    .key_rdy (key_rdy),
    .key_in  (key_in),
    .rk_idx  (rk_idx),
    .rk_out  (rk_out),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (word-oriented FIPS-197) ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] c = 8'h63;
    logic [7:0] s;
    for (int y = 1; y < 256; y++)
      if (x != 0 && mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {ref_sbox(t[31:24]) ^ rc, ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic send_beat(input logic [31:0] w);
    key_vld = 1'b1;
    key_in  = w;
    @(negedge clk);
    key_vld = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] key, input int gap);
    for (int i = 0; i < 4; i++) begin
      repeat (gap) @(negedge clk);
      send_beat(key[127 - 32*i -: 32]);
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [127:0] val);
    rk_idx = idx;
    @(negedge clk);
    val = rk_out;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [127:0] v;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (key_rdy !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || rk_out !== '0) begin
      errors++;
      $display("FAIL reset_hold: rdy=%b done=%b busy=%b rk_out=%h, want 1 0 0 0", key_rdy, done, busy, rk_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (key_rdy !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b done=%b busy=%b, want 1 0 0", key_rdy, done, busy);
    end
    read_rk(4'd10, v);
    checks++;
    if (v !== '0) begin errors++; $display("FAIL reset_rk10: got %h want 0", v); end
  endtask

  task automatic test_fips;
    logic [127:0] v;
    int n;
    model_expand(C_FIPS_KEY);
    checks++;
    if (m_rk[1] !== C_FIPS_RK1 || m_rk[10] !== C_FIPS_RK10) begin
      errors++;
      $display("FAIL model_fips: rk1=%h rk10=%h want %h %h", m_rk[1], m_rk[10], C_FIPS_RK1, C_FIPS_RK10);
    end
    load_key(C_FIPS_KEY, 0);
    checks++;
    if (busy !== 1'b1 || key_rdy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL fips_expand_start: busy=%b rdy=%b done=%b want 1 0 0", busy, key_rdy, done);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n != 10) begin errors++; $display("FAIL fips_latency: got %0d cycles want 10", n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL fips_busy_end: got %b want 0", busy); end
    read_rk(4'd1, v);
    checks++;
    if (v !== C_FIPS_RK1) begin errors++; $display("FAIL fips_rk1: got %h want %h", v, C_FIPS_RK1); end
    read_rk(4'd10, v);
    checks++;
    if (v !== C_FIPS_RK10) begin errors++; $display("FAIL fips_rk10: got %h want %h", v, C_FIPS_RK10); end
    read_rk(4'd0, v);
    checks++;
    if (v !== C_FIPS_KEY) begin errors++; $display("FAIL fips_rk0: got %h want %h", v, C_FIPS_KEY); end
  endtask

  task automatic test_gaps_vld_hold;
    logic [127:0] v;
    int n;
    load_key(C_FIPS_KEY, 3);
    key_vld = 1'b1;
    key_in  = $urandom;
    n = 0;
    while (key_rdy !== 1'b1 && n < 20) begin n++; @(negedge clk); key_in = $urandom; end
    key_vld = 1'b0;
    checks++;
    if (n != 10) begin errors++; $display("FAIL gaps_rdy_low: got %0d cycles want 10", n); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL gaps_done: got %b want 1", done); end
    read_rk(4'd10, v);
    checks++;
    if (v !== C_FIPS_RK10) begin errors++; $display("FAIL gaps_rk10: got %h want %h", v, C_FIPS_RK10); end
    read_rk(4'd0, v);
    checks++;
    if (v !== C_FIPS_KEY || done !== 1'b1) begin
      errors++;
      $display("FAIL gaps_no_extra_beat: rk0=%h done=%b want %h 1", v, done, C_FIPS_KEY);
    end
  endtask

  task automatic test_read_index;
    logic [127:0] v;
    read_rk(4'd1, v);
    rk_idx = 4'd10;
    #1;
    checks++;
    if (rk_out !== C_FIPS_RK1) begin errors++; $display("FAIL idx_no_early: got %h want %h", rk_out, C_FIPS_RK1); end
    @(negedge clk);
    checks++;
    if (rk_out !== C_FIPS_RK10) begin errors++; $display("FAIL idx_one_cycle: got %h want %h", rk_out, C_FIPS_RK10); end
    read_rk(4'd11, v);
    checks++;
    if (v !== '0) begin errors++; $display("FAIL idx_11: got %h want 0", v); end
    read_rk(4'd15, v);
    checks++;
    if (v !== '0) begin errors++; $display("FAIL idx_15: got %h want 0", v); end
  endtask

  task automatic test_reset_mid_expand;
    logic [127:0] v;
    int n;
    load_key(C_FIPS_KEY ^ 128'h1, 0);
    rk_idx = 4'd0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rk_out !== '0 || done !== 1'b0 || busy !== 1'b0 || key_rdy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: rk_out=%h done=%b busy=%b rdy=%b want 0 0 0 1", rk_out, done, busy, key_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    read_rk(4'd1, v);
    checks++;
    if (v !== '0) begin errors++; $display("FAIL reset_no_partial: got %h want 0", v); end
    load_key(C_FIPS_KEY, 1);
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n != 10) begin errors++; $display("FAIL reload_latency: got %0d want 10", n); end
    read_rk(4'd10, v);
    checks++;
    if (v !== C_FIPS_RK10) begin errors++; $display("FAIL reload_rk10: got %h want %h", v, C_FIPS_RK10); end
  endtask

  task automatic test_zero_key;
    logic [127:0] v;
    int n;
    send_beat(32'h0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || key_rdy !== 1'b1) begin
      errors++;
      $display("FAIL zero_first_beat: done=%b busy=%b rdy=%b want 0 0 1", done, busy, key_rdy);
    end
    read_rk(4'd10, v);
    checks++;
    if (v !== C_FIPS_RK10) begin errors++; $display("FAIL zero_stale_rk10: got %h want %h", v, C_FIPS_RK10); end
    repeat (3) send_beat(32'h0);
    n = 0;
    while (busy === 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n != 10 || done !== 1'b1) begin errors++; $display("FAIL zero_busy: got %0d cycles done=%b want 10 1", n, done); end
    read_rk(4'd10, v);
    checks++;
    if (v !== C_ZERO_RK10) begin errors++; $display("FAIL zero_rk10: got %h want %h", v, C_ZERO_RK10); end
  endtask

  task automatic test_random_keys;
    logic [127:0] key;
    logic [127:0] v;
    int n;
    for (int k = 0; k < 3; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      model_expand(key);
      load_key(key, int'($urandom_range(0, 2)));
      n = 0;
      while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (n != 10) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 10", k, n); end
      for (int r = 0; r < 11; r++) begin
        read_rk(4'(r), v);
        checks++;
        if (v !== m_rk[r]) begin errors++; $display("FAIL rand_rk[%0d][%0d]: got %h want %h", k, r, v, m_rk[r]); end
      end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    key_vld = 1'b0;
    key_in  = '0;
    rk_idx  = '0;
    @(negedge clk);
    test_reset();
    test_fips();
    test_gaps_vld_hold();
    test_read_index();
    test_reset_mid_expand();
    test_zero_key();
    test_random_keys();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_key_sched.md
AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset, with ports as follows.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_vld  in  1  input key word valid.
- key_rdy  out  1  block accepts a key word this cycle.
- key_in  in  32  cipher-key word; first beat is the most significant word.
- rk_idx  in  4  round-key read index, 0..10.
- rk_out  out  128  registered round-key read data.
- done  out  1  all 11 round keys are valid.
- busy  out  1  expansion in progress.
REQ-002 The module SHALL instantiate one aes_keyexp (rnd, di_key, do_key) as its round function; no other S-box logic is permitted.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, EXPAND and READY.
REQ-004 key_rdy SHALL be 1 in IDLE, LOAD and READY, and 0 in EXPAND.
REQ-005 A beat SHALL transfer only on a rising edge with key_vld=1 and key_rdy=1.
REQ-006 A 2-bit beat counter SHALL select the destination of each beat: beats 0..3 write rk[0] bits [127:96], [95:64], [63:32] and [31:0] respectively.
REQ-007 The first beat in IDLE or READY SHALL move the FSM to LOAD and clear done in the same edge.
REQ-008 The fourth beat, with counter=3, SHALL move the FSM to EXPAND, set the round counter to 1 and reset the beat counter to 0.
REQ-009 Beats SHALL be gap-tolerant: key_vld low in LOAD holds all state.
REQ-010 In EXPAND, each cycle SHALL drive aes_keyexp with rnd=round counter and di_key=rk[round counter-1].
- The rising edge SHALL write do_key into rk[round counter] and increment the counter.
REQ-011 When the round counter is 10, the edge SHALL write rk[10], move the FSM to READY and set done=1.
REQ-012 Expansion latency SHALL be fixed: 4th beat accepted at edge N gives rk[1]..rk[10] written at edges N+1..N+10 and done=1 from edge N+10.
REQ-013 busy SHALL equal 1 exactly while the FSM is in EXPAND.
REQ-014 key_vld asserted in EXPAND SHALL be ignored: no transfer, and no state or counter change.
REQ-015 rk_out SHALL be registered: at each edge it loads rk[rk_idx] if rk_idx<=10, else 128'h0.
- Read latency is 1 cycle, and reads are allowed in every state.
REQ-016 Reads of indices not yet written in the current expansion SHALL return the prior contents (stale data); done is the only validity indicator.
REQ-017 The round counter SHALL never exceed 10 and SHALL never pass rnd=0 or rnd>10 to aes_keyexp while busy=1; when idle, rnd SHALL be driven as 1.
REQ-018 Reloading from READY SHALL overwrite rk[0] word-by-word, and the following expansion SHALL overwrite rk[1..10].

Reset
REQ-019 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state IDLE; beat and round counters 0;
- all rk[0..10] = 0;
- rk_out = 0; done = 0; busy = 0.
REQ-020 key_rdy SHALL be 1 while rst_n=0 and after release.
REQ-021 Reset asserted mid-LOAD or mid-EXPAND SHALL abort the operation with no partial result retained; after release, the next beat is treated as beat 0.

Verification
REQ-022 FIPS-197 key: beats 2b7e1516, 28aed2a6, abf71588, 09cf4f3c with no gaps -> done rises exactly 10 cycles after the 4th beat, and the following reads return:
- rk_idx=1 -> a0fafe17_88542cb1_23a33939_2a6c7605;
- rk_idx=10 -> d014f9a8_c9ee2589_e13f0cc8_b6630ca6;
- rk_idx=0 -> the loaded key.
REQ-023 Same key with 3 idle cycles between beats, and key_vld held high throughout EXPAND -> key_rdy=0 for exactly 10 cycles, identical rk[10], and no extra beat is consumed.
REQ-024 rk_idx=11 and rk_idx=15 -> rk_out=0 one cycle later; after a change of rk_idx, rk_out changes exactly one cycle later.
REQ-025 rst_n pulsed low during the 5th EXPAND cycle -> outputs go to 0 asynchronously; then reload the FIPS key -> correct rk[10] and done=1.
REQ-026 In READY, load an all-zero key -> done clears on the first beat, busy=1 for 10 cycles, and rk[10]=b4ef5bcb_3e92e211_23e951cf_6f8f188e.
